// File: rtl/ad9866_pkg.sv
// Shared types and constants for the AD9866 control-port sequencer:
// FSM states, SPI frame width and the power-up register table.
package ad9866_pkg;

  localparam int unsigned SPI_W    = 16;
  localparam int unsigned INIT_MAX = 8;

  typedef enum logic [2:0] {
    StRstHold,
    StRstWait,
    StLoad,
    StShift,
    StGap,
    StIdle
  } state_e;

  // {addr[4:0], data[7:0]}; entry 0 is the rightmost element.
  localparam logic [INIT_MAX-1:0][12:0] INIT_TBL = {
    {5'h0E, 8'h81},  // TX gain
    {5'h09, 8'h20},  // PGA control
    {5'h08, 8'h80},
    {5'h07, 8'h08},
    {5'h04, 8'h36},
    {5'h03, 8'h00},
    {5'h02, 8'h0C},
    {5'h01, 8'h54}   // RX/TX mode
  };

  function automatic logic [SPI_W-1:0] make_frame(input logic       rnw,
                                                  input logic [4:0] addr,
                                                  input logic [7:0] data);
    return {rnw, 2'b00, addr, data};
  endfunction

endpackage

// File: rtl/ad9866_spi_ctrl_if.sv
// Command handshake between the core's control decoder and the AD9866 sequencer.
interface ad9866_spi_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rnw;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_data,
    input  cmd_ready, rd_data, rd_valid
  );

  modport slave (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_data,
    output cmd_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/ad9866_spi_shift.sv
// 16-bit SPI frame engine: drives sen_n/sclk/sdio from a start pulse and
// captures the read-back byte from sdo; done is high in the last SCLK half-period.
module ad9866_spi_shift
  import ad9866_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rnw,
  input  logic [SPI_W-1:0] frame,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             sen_n,
  output logic             sclk,
  output logic             sdio,
  input  logic             sdo
);

  localparam int unsigned DivW = $clog2(CLK_DIV);

  logic             active_q;
  logic [DivW-1:0]  div_q;
  logic [4:0]       bit_q;
  logic [SPI_W-1:0] sr_q;
  logic [7:0]       rx_q;
  logic             rnw_q;
  logic             div_wrap, rise, fall;

  always_comb begin
    div_wrap = (div_q == DivW'(CLK_DIV - 1));
    rise     = active_q && !sclk && div_wrap;
    fall     = active_q && sclk && div_wrap;
    done     = fall && (bit_q == 5'(SPI_W - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      rx_q     <= '0;
      rnw_q    <= 1'b0;
      sen_n    <= 1'b1;
      sclk     <= 1'b0;
      sdio     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (start) begin
        active_q <= 1'b1;
        div_q    <= '0;
        bit_q    <= '0;
        sr_q     <= frame;
        rnw_q    <= rnw;
        sen_n    <= 1'b0;
        sclk     <= 1'b0;
        sdio     <= frame[SPI_W-1];
      end else if (active_q) begin
        div_q <= div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) sclk <= ~sclk;
        // Only the data-phase rising edges carry the codec's reply.
        if (rise && rnw_q && (bit_q >= 5'd8)) rx_q <= {rx_q[6:0], sdo};
        if (fall) begin
          bit_q <= bit_q + 1'b1;
          sr_q  <= {sr_q[SPI_W-2:0], 1'b0};
          sdio  <= sr_q[SPI_W-2];
        end
        if (done) begin
          active_q <= 1'b0;
          sen_n    <= 1'b1;
          sdio     <= 1'b0;
          if (rnw_q) begin
            rd_data  <= rx_q;
            rd_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ad9866_spi_ctrl.sv
// AD9866 control-port sequencer: codec reset, power-up table writes, then
// single-register write/read commands from the core over a valid/ready handshake.
module ad9866_spi_ctrl
  import ad9866_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned RST_CYC = 64,
  parameter int unsigned INIT_N  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  ad9866_spi_ctrl_if.slave   cmd,
  output logic               init_done,
  output logic               busy,
  output logic               ad9866_rst_n,
  output logic               ad9866_sen_n,
  output logic               ad9866_sclk,
  output logic               ad9866_sdio,
  input  logic               ad9866_sdo
);

  localparam int unsigned CntMax = (RST_CYC > 2 * CLK_DIV) ? RST_CYC : 2 * CLK_DIV;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam int unsigned IdxW   = $clog2(INIT_N + 1);
  localparam int unsigned TblW   = $clog2(INIT_MAX);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             done_q, done_d;
  logic             rnw_q, rnw_d;
  logic [4:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             rst_pin_q;
  logic             start, shift_done, ready;
  logic [12:0]      tbl_word;
  logic [SPI_W-1:0] frame;
  logic [7:0]       rd_data;
  logic             rd_valid;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    done_d   = done_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    data_d   = data_q;
    start    = 1'b0;
    ready    = 1'b0;
    tbl_word = INIT_TBL[TblW'(idx_q)];
    frame    = done_q ? make_frame(rnw_q, addr_q, data_q)
                      : make_frame(1'b0, tbl_word[12:8], tbl_word[7:0]);
    unique case (state_q)
      StRstHold: begin
        if (cnt_q == CntW'(RST_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StRstWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRstWait: begin
        if (cnt_q == CntW'(RST_CYC - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLoad: begin
        start   = 1'b1;
        if (!done_q) idx_d = idx_q + 1'b1;
        state_d = StShift;
      end
      StShift: begin
        if (shift_done) begin
          cnt_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(2 * CLK_DIV - 1)) begin
          cnt_d = '0;
          if (done_q) begin
            state_d = StIdle;
          end else if (idx_q < IdxW'(INIT_N)) begin
            state_d = StLoad;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        ready = 1'b1;
        // Latch now so the core may change addr/data right after acceptance.
        if (cmd.cmd_valid) begin
          rnw_d   = cmd.cmd_rnw;
          addr_d  = cmd.cmd_addr;
          data_d  = cmd.cmd_data;
          state_d = StLoad;
        end
      end
      default: state_d = StRstHold;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StRstHold;
      cnt_q     <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rst_pin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rst_pin_q <= (state_d != StRstHold);
    end
  end

  ad9866_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rnw      (done_q ? rnw_q : 1'b0),
    .frame    (frame),
    .done     (shift_done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .sen_n    (ad9866_sen_n),
    .sclk     (ad9866_sclk),
    .sdio     (ad9866_sdio),
    .sdo      (ad9866_sdo)
  );

  assign cmd.cmd_ready = ready;
  assign cmd.rd_data   = rd_data;
  assign cmd.rd_valid  = rd_valid;
  assign init_done     = done_q;
  assign busy          = (state_q != StIdle);
  assign ad9866_rst_n  = rst_pin_q;

endmodule
